// File: rtl/uartprobe_uart_rx.sv
`default_nettype none
// -----------------------------------------------------------------------------
// uartprobe_uart_rx : oversampling 8N1 UART receiver with valid/ready output
// Rev 1.0
// -----------------------------------------------------------------------------
module uartprobe_uart_rx #(
  parameter int CYCLES_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       aresetn,
  input  logic       uart_rxd,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic       framing_error,
  output logic       overrun
);

  localparam int CNT_W = $clog2(CYCLES_PER_BIT);
  localparam int HALF  = CYCLES_PER_BIT / 2;
  localparam logic [CNT_W-1:0] C_HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] C_BIT_LAST  = CNT_W'(CYCLES_PER_BIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             done_q, done_d;
  logic             stop_ok_q, stop_ok_d;
  logic             rx_valid_q, rx_valid_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             framing_error_q, framing_error_d;
  logic             overrun_q, overrun_d;

  logic rxd_s;
  logic frame_good;

  assign sync_d     = {sync_q[0], uart_rxd};
  assign rxd_s      = sync_q[1];
  assign frame_good = done_q && stop_ok_q;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q         <= ST_IDLE;
      sync_q          <= 2'b11;
      cnt_q           <= '0;
      bit_idx_q       <= 3'd0;
      shift_q         <= 8'h00;
      done_q          <= 1'b0;
      stop_ok_q       <= 1'b0;
      rx_valid_q      <= 1'b0;
      rx_data_q       <= 8'h00;
      framing_error_q <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      sync_q          <= sync_d;
      cnt_q           <= cnt_d;
      bit_idx_q       <= bit_idx_d;
      shift_q         <= shift_d;
      done_q          <= done_d;
      stop_ok_q       <= stop_ok_d;
      rx_valid_q      <= rx_valid_d;
      rx_data_q       <= rx_data_d;
      framing_error_q <= framing_error_d;
      overrun_q       <= overrun_d;
    end
  end

  // Deframer; done_q/stop_ok_q carry the stop-bit verdict one cycle forward.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    done_d    = 1'b0;
    stop_ok_d = stop_ok_q;
    case (state_q)
      ST_IDLE: begin
        if (!rxd_s) begin
          cnt_d   = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (cnt_q == C_HALF_LAST) begin
          if (rxd_s) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d     = '0;
            bit_idx_d = 3'd0;
            state_d   = ST_DATA;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == C_BIT_LAST) begin
          cnt_d     = '0;
          shift_d   = {rxd_s, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (cnt_q == C_BIT_LAST) begin
          cnt_d     = '0;
          done_d    = 1'b1;
          stop_ok_d = rxd_s;
          state_d   = rxd_s ? ST_IDLE : ST_BREAK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_BREAK: begin
        if (rxd_s) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A consumer draining the register in the load cycle makes room for the new byte.
  always_comb begin
    rx_valid_d      = rx_valid_q;
    rx_data_d       = rx_data_q;
    framing_error_d = done_q && !stop_ok_q;
    overrun_d       = 1'b0;
    if (frame_good) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  assign rx_valid      = rx_valid_q;
  assign rx_data       = rx_data_q;
  assign framing_error = framing_error_q;
  assign overrun       = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_uartprobe_uart_rx.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_uartprobe_uart_rx : table, directed and random checks of the UART receiver
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_uartprobe_uart_rx;

  localparam int C    = 16;
  localparam int HALF = C / 2;
  localparam int LAT  = 2 + HALF + 9 * C + 1;

  logic       clk = 1'b0;
  logic       aresetn;
  logic       uart_rxd;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       framing_error;
  logic       overrun;

  uartprobe_uart_rx #(.CYCLES_PER_BIT(C)) dut (
    .clk           (clk),
    .aresetn       (aresetn),
    .uart_rxd      (uart_rxd),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .rx_ready      (rx_ready),
    .framing_error (framing_error),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [7:0] d;
  } ev_t;

  ev_t q_vrise[$], q_vfall[$], q_ferr[$], q_ovr[$], q_acc[$];
  ev_t exp_v[$], exp_f[$];

  logic       p_valid = 1'b0;
  logic       p_hs    = 1'b0;
  logic [7:0] p_data  = 8'h00;
  int         stab_err = 0;

  always @(negedge clk) begin
    if (rx_valid && !p_valid) q_vrise.push_back('{cyc, rx_data});
    if (!rx_valid && p_valid) q_vfall.push_back('{cyc, rx_data});
    if (framing_error)        q_ferr.push_back('{cyc, rx_data});
    if (overrun)              q_ovr.push_back('{cyc, rx_data});
    if (rx_valid && rx_ready) q_acc.push_back('{cyc + 1, rx_data});
    if (p_valid && rx_valid && !p_hs && rx_data != p_data) stab_err <= stab_err + 1;
    p_valid <= rx_valid;
    p_hs    <= rx_valid && rx_ready;
    p_data  <= rx_data;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic to_edge(input int x);
    while (cyc < x) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_q();
    q_vrise.delete(); q_vfall.delete(); q_ferr.delete(); q_ovr.delete(); q_acc.delete();
  endtask

  // Called aligned at #1 after an edge; t0 is the first edge that samples the start bit.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int hold_low, output int t0);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    t0   = cyc + 1;
    for (int i = 0; i < 10; i++) begin
      uart_rxd = bits[i];
      idle(C);
    end
    if (!stop) idle(hold_low);
    uart_rxd = 1'b1;
  endtask

  task automatic glitch(input int n);
    uart_rxd = 1'b0;
    idle(n);
    uart_rxd = 1'b1;
  endtask

  typedef struct {
    logic       is_glitch;
    logic [7:0] data;
    logic       stop;
    int         hold;
    int         exp_nv;
    logic [7:0] exp_d;
    int         exp_nf;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0, t0a, t0b, nbad;
    logic [7:0] d;
    logic bad;

    tbl[0] = '{1'b0, 8'hA5, 1'b1, 0,  1, 8'hA5, 0};
    tbl[1] = '{1'b1, 8'h00, 1'b1, 4,  0, 8'h00, 0};
    tbl[2] = '{1'b0, 8'h3C, 1'b1, 0,  1, 8'h3C, 0};
    tbl[3] = '{1'b0, 8'h55, 1'b0, 40, 0, 8'h00, 1};
    tbl[4] = '{1'b0, 8'h81, 1'b1, 0,  1, 8'h81, 0};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 0,  1, 8'h00, 0};
    tbl[6] = '{1'b0, 8'hFF, 1'b0, 3,  0, 8'h00, 1};
    tbl[7] = '{1'b0, 8'hFF, 1'b1, 0,  1, 8'hFF, 0};

    aresetn  = 1'b0;
    uart_rxd = 1'b1;
    rx_ready = 1'b0;
    idle(4);
    chk("reset_valid", rx_valid, 0);
    chk("reset_data", rx_data, 0);
    chk("reset_ferr", framing_error, 0);
    chk("reset_ovr", overrun, 0);
    aresetn = 1'b1;
    idle(C);

    // Table-driven frames, consumer always ready.
    rx_ready = 1'b1;
    foreach (tbl[i]) begin
      clear_q();
      if (tbl[i].is_glitch) begin
        t0 = cyc + 1;
        glitch(tbl[i].hold);
      end else begin
        send_frame(tbl[i].data, tbl[i].stop, tbl[i].hold, t0);
      end
      idle(LAT + 2 * C);
      chk($sformatf("v%0d_nvalid", i), q_vrise.size(), tbl[i].exp_nv);
      if (tbl[i].exp_nv > 0 && q_vrise.size() > 0) begin
        chk($sformatf("v%0d_valid_edge", i), q_vrise[0].cyc, t0 + LAT);
        chk($sformatf("v%0d_data", i), q_vrise[0].d, tbl[i].exp_d);
        chk($sformatf("v%0d_nfall", i), q_vfall.size(), 1);
        if (q_vfall.size() > 0) chk($sformatf("v%0d_valid_width", i), q_vfall[0].cyc, t0 + LAT + 1);
      end
      chk($sformatf("v%0d_nferr", i), q_ferr.size(), tbl[i].exp_nf);
      if (tbl[i].exp_nf > 0 && q_ferr.size() > 0)
        chk($sformatf("v%0d_ferr_edge", i), q_ferr[0].cyc, t0 + LAT);
      chk($sformatf("v%0d_novr", i), q_ovr.size(), 0);
    end

    // Overrun: two back-to-back frames with no consumer.
    clear_q();
    rx_ready = 1'b0;
    stab_err = 0;
    send_frame(8'h11, 1'b1, 0, t0a);
    send_frame(8'h22, 1'b1, 0, t0b);
    idle(2 * C);
    chk("ovr_t0b", t0b, t0a + 10 * C);
    chk("ovr_nvalid", q_vrise.size(), 1);
    if (q_vrise.size() > 0) chk("ovr_first_data", q_vrise[0].d, 8'h11);
    chk("ovr_npulse", q_ovr.size(), 1);
    if (q_ovr.size() > 0) chk("ovr_edge", q_ovr[0].cyc, t0b + LAT);
    chk("ovr_hold_valid", rx_valid, 1);
    chk("ovr_hold_data", rx_data, 8'h11);
    chk("ovr_stable", stab_err, 0);
    rx_ready = 1'b1;
    idle(3);
    chk("ovr_nacc", q_acc.size(), 1);
    if (q_acc.size() > 0) chk("ovr_acc_data", q_acc[0].d, 8'h11);
    chk("ovr_valid_fall", rx_valid, 0);

    // Same-cycle accept and load of the second frame.
    clear_q();
    rx_ready = 1'b0;
    t0a = cyc + 1;
    fork
      begin
        send_frame(8'h11, 1'b1, 0, t0a);
        send_frame(8'h22, 1'b1, 0, t0b);
      end
      begin
        to_edge(t0a + 10 * C + LAT - 1);
        rx_ready = 1'b1;
      end
    join
    idle(2 * C);
    chk("sca_novr", q_ovr.size(), 0);
    chk("sca_nrise", q_vrise.size(), 1);
    chk("sca_nacc", q_acc.size(), 2);
    if (q_acc.size() == 2) begin
      chk("sca_acc0_data", q_acc[0].d, 8'h11);
      chk("sca_acc0_edge", q_acc[0].cyc, t0b + LAT);
      chk("sca_acc1_data", q_acc[1].d, 8'h22);
    end
    chk("sca_nfall", q_vfall.size(), 1);
    if (q_vfall.size() > 0) chk("sca_fall_edge", q_vfall[0].cyc, t0b + LAT + 1);

    // Reset mid-frame with a byte already held.
    rx_ready = 1'b0;
    send_frame(8'h5A, 1'b1, 0, t0);
    idle(C);
    chk("rst_pre_valid", rx_valid, 1);
    uart_rxd = 1'b0;
    idle(C);
    for (int b = 0; b < 3; b++) begin
      uart_rxd = b[0] ? 1'b0 : 1'b0;
      idle(C);
    end
    uart_rxd = 1'b0;
    idle(HALF);
    #3;
    aresetn = 1'b0;
    #1;
    chk("rst_async_valid", rx_valid, 0);
    chk("rst_async_data", rx_data, 0);
    chk("rst_async_ferr", framing_error, 0);
    chk("rst_async_ovr", overrun, 0);
    uart_rxd = 1'b1;
    idle(2);
    #2;
    aresetn = 1'b1;
    idle(C + 2);
    clear_q();
    rx_ready = 1'b1;
    send_frame(8'h0F, 1'b1, 0, t0);
    idle(2 * C);
    chk("rst_post_nvalid", q_vrise.size(), 1);
    if (q_vrise.size() > 0) begin
      chk("rst_post_edge", q_vrise[0].cyc, t0 + LAT);
      chk("rst_post_data", q_vrise[0].d, 8'h0F);
    end
    chk("rst_post_nferr", q_ferr.size(), 0);

    // Random frames against a timing/sequence reference.
    clear_q();
    exp_v.delete();
    exp_f.delete();
    nbad = 0;
    for (int n = 0; n < 14; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        glitch($urandom_range(1, HALF - 2));
        idle(C);
      end
      d   = 8'($urandom);
      bad = ($urandom_range(0, 3) == 0);
      send_frame(d, !bad, $urandom_range(0, 30), t0);
      if (bad) begin
        exp_f.push_back('{t0 + LAT, 8'h00});
        nbad++;
        idle($urandom_range(2, 20));
      end else begin
        exp_v.push_back('{t0 + LAT, d});
        idle($urandom_range(0, 20));
      end
    end
    idle(LAT + C);
    chk("rnd_nvalid", q_vrise.size(), exp_v.size());
    chk("rnd_nferr", q_ferr.size(), nbad);
    chk("rnd_novr", q_ovr.size(), 0);
    for (int k = 0; k < exp_v.size() && k < q_vrise.size(); k++) begin
      chk($sformatf("rnd_v%0d_edge", k), q_vrise[k].cyc, exp_v[k].cyc);
      chk($sformatf("rnd_v%0d_data", k), q_vrise[k].d, exp_v[k].d);
    end
    for (int k = 0; k < exp_f.size() && k < q_ferr.size(); k++)
      chk($sformatf("rnd_f%0d_edge", k), q_ferr[k].cyc, exp_f[k].cyc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uartprobe_uart_rx.md
# uartprobe_uart_rx

UART receiver front end for the probe. It oversamples the asynchronous serial input, deframes 8N1 characters and presents each received byte on a valid/ready handshake. That handshake feeds the `rx_valid`/`rx_data`/`rx_ready` input of the GPIO register command block. Framing errors and overruns are reported as single-cycle pulses.

## Interface

- `CYCLES_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200). Must be ≥ 4.
- `clk`  input  1: sole clock; all logic on the rising edge.
- `aresetn`  input  1: asynchronous, active-low reset.
- `uart_rxd`  input  1: asynchronous serial line; idles high.
- `rx_valid`  output  1: `rx_data` holds an unconsumed byte.
- `rx_data`  output  8: received byte, LSB = first data bit.
- `rx_ready`  input  1: downstream accepts `rx_data` this cycle.
- `framing_error`  output  1: one-cycle pulse when the stop bit is sampled low.
- `overrun`  output  1: one-cycle pulse when a good frame is dropped because the holding register is full.

## Operation

- **Synchronizer.** `uart_rxd` passes through a 2-flop synchronizer whose flops reset to 1. All decisions use the synchronized value `rxd_s`.
- **Counters.** The bit-time counter is `$clog2(CYCLES_PER_BIT)` bits wide. The bit index is 3 bits. `HALF = CYCLES_PER_BIT/2` (integer division).
- **IDLE**
  - When `rxd_s` = 0, clear the counter and go to START.
- **START**
  - Count to `HALF`, then sample.
  - Sample = 1: glitch. Return to IDLE with no output and no error.
  - Sample = 0: clear the counter and bit index, go to DATA.
- **DATA**
  - Every `CYCLES_PER_BIT` cycles, shift the sample into the MSB of the shift register (LSB-first reception).
  - After the 8th sample, go to STOP.
- **STOP**
  - After `CYCLES_PER_BIT` cycles, sample.
  - Sample = 1: frame good. Deliver the byte (see holding register), go to IDLE.
  - Sample = 0: pulse `framing_error`, discard the byte, go to BREAK.
- **BREAK**
  - Wait until `rxd_s` = 1, then go to IDLE. A held-low line produces exactly one `framing_error`.
- **Resync.** The receiver returns to IDLE at mid-stop-bit, so it can catch a start bit that begins immediately after the stop bit.
- **Holding register** (`rx_valid`, `rx_data`)
  - A handshake completes in any cycle with `rx_valid && rx_ready`.
  - Good frame with `rx_valid` = 0: load `rx_data`, set `rx_valid`.
  - Good frame while a handshake completes in the same cycle: load the new byte, keep `rx_valid` = 1. No overrun.
  - Good frame with `rx_valid` = 1 and `rx_ready` = 0: keep the old byte, pulse `overrun`, drop the new byte.
  - Handshake with no new frame that cycle: clear `rx_valid`.
  - `rx_data` is stable while `rx_valid` = 1 and is never cleared on consumption.
- **Reset.** `rx_valid`, `rx_data`, `framing_error` and `overrun` all reset to 0. The FSM resets to IDLE and the synchronizer to 1. Reset mid-frame abandons the frame; the partial byte is never delivered.

## Timing

- Synchronizer latency: 2 cycles. Cycle 0 = the first clock edge that samples `uart_rxd` low; `rxd_s` goes low at edge 2.
- Sample edges, relative to cycle 0:
  - Start bit: 2 + `HALF`.
  - Data bit i (i = 0..7): 2 + `HALF` + (i+1)·`CYCLES_PER_BIT`.
  - Stop bit: 2 + `HALF` + 9·`CYCLES_PER_BIT`.
- `rx_valid` rises, or the `framing_error`/`overrun` pulse occurs, at stop-sample edge + 1.
- Each pulse output is high for exactly one cycle.
- `rx_ready` is combinationally ignored; there is no path from `rx_ready` to any output within the same cycle.
- Sustained throughput: one byte per 10 bit-times. Tolerates ±4% baud mismatch when `CYCLES_PER_BIT` ≥ 16.

## Test plan

All scenarios use `CYCLES_PER_BIT` = 16.

- **Nominal byte.** Send 0xA5 (8N1) with `rx_ready` = 1 → `rx_valid` high at edge 155 after cycle 0, for 1 cycle, `rx_data` = 0xA5. No `framing_error`, no `overrun`.
- **Start-bit glitch.** Drive `uart_rxd` low for 4 cycles, then high → no `rx_valid` and no `framing_error`. A following 0x3C frame is received correctly.
- **Framing error.** Send 0x55 with the stop bit low, then hold the line low for 40 cycles before returning high → exactly one `framing_error` pulse at edge 155 and `rx_valid` stays 0. A subsequent 0x81 frame is received as 0x81.
- **Overrun.** Send 0x11 then 0x22 back-to-back with `rx_ready` = 0 → `rx_valid` = 1 with `rx_data` = 0x11 throughout. One `overrun` pulse at the second frame's stop-sample + 1. Raising `rx_ready` delivers 0x11 and `rx_valid` then falls.
- **Same-cycle accept and load.** Send 0x11, 0x22 back-to-back with `rx_ready` rising exactly at the second frame's load edge → no `overrun`. `rx_data` changes from 0x11 to 0x22 with `rx_valid` continuously 1.
- **Reset mid-frame.** Assert `aresetn` low during data bit 3 of 0xF0 → all outputs 0 immediately. After release and a full idle bit, frame 0x0F yields `rx_data` = 0x0F.
